// File: rtl/regfile_init.sv
// -----------------------------------------------------------------------------
// regfile_init
//
// Integer register file (x0..x31) for the RV32I pipeline. It has two
// combinational read ports for decode and one synchronous write port for
// write-back. After every reset a clear sequencer walks x1..x31 and writes
// zero into each one. While it runs, init_busy_o tells the pipeline to stall.
//
// Configuration macro:
//   REGFILE_BYPASS_EN - when defined, a write in RUN is forwarded to any read
//                       port that addresses the same (non-zero) register in
//                       the same cycle. When undefined, reads return the
//                       pre-write contents during the write cycle.
//
// Ports:
//   clk          in   clock; all state updates on the rising edge
//   rst          in   synchronous active-high reset; restarts the clear
//   rs1_addr_i   in   [AW-1:0] read port 1 address
//   rs2_addr_i   in   [AW-1:0] read port 2 address
//   rs1_data_o   out  [DW-1:0] read port 1 data (0 while clearing or for x0)
//   rs2_data_o   out  [DW-1:0] read port 2 data (0 while clearing or for x0)
//   rd_addr_i    in   [AW-1:0] write address
//   rd_data_i    in   [DW-1:0] write data
//   reg_wen_i    in   write enable (dropped while clearing, never for x0)
//   init_busy_o  out  clear sequence in progress
// -----------------------------------------------------------------------------
module regfile_init #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rs1_addr_i,
    input  logic [AW-1:0] rs2_addr_i,
    output logic [DW-1:0] rs1_data_o,
    output logic [DW-1:0] rs2_data_o,
    input  logic [AW-1:0] rd_addr_i,
    input  logic [DW-1:0] rd_data_i,
    input  logic          reg_wen_i,
    output logic          init_busy_o
);

    localparam int NREG = 1 << AW;

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    localparam logic [AW-1:0] CLR_FIRST = AW'(1);
    localparam logic [AW-1:0] CLR_LAST  = {AW{1'b1}};

    logic [0:0]    state;
    logic [AW-1:0] clr_cnt;
    logic          run_wr;

    // Entry 0 is never written and never read. Reads of x0 are forced to zero.
    logic [DW-1:0] regs [NREG];

    assign run_wr = (state == RUN) && reg_wen_i && (rd_addr_i != '0);

    // Control: the clear sequencer starts at x1 and hands over to RUN after x31.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= CLR_FIRST;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + AW'(1);
            if (clr_cnt == CLR_LAST) begin
                state <= RUN;
            end
        end
    end

    // Storage has no reset of its own. The clear sequence zeroes it.
    // The reset cycle itself writes nothing, so a write requested then is lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[clr_cnt] <= '0;
            end else if (run_wr) begin
                regs[rd_addr_i] <= rd_data_i;
            end
        end
    end

    function automatic logic [DW-1:0] read_port(input logic [AW-1:0] addr);
        logic [DW-1:0] data;
        data = '0;
        if (state == RUN && addr != '0) begin
`ifdef REGFILE_BYPASS_EN
            if (run_wr && rd_addr_i == addr) begin
                data = rd_data_i;
            end else begin
                data = regs[addr];
            end
`else
            data = regs[addr];
`endif
        end
        return data;
    endfunction

    always_comb begin
        rs1_data_o = read_port(rs1_addr_i);
        rs2_data_o = read_port(rs2_addr_i);
    end

    // Decoded straight from the state register, so there is no path from the inputs.
    assign init_busy_o = (state == CLEAR);

endmodule

// File: tb/tb_regfile_init.sv
// -----------------------------------------------------------------------------
// tb_regfile_init
//
// Self-checking bench for regfile_init. A behavioural model tracks two things:
// the architectural register contents and the number of clear cycles still
// left. Every cycle after the first reset, it predicts busy and both read
// ports and compares them with the DUT. Directed vectors with literal
// expectations pin down the model's own behaviour.
// Honours REGFILE_BYPASS_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_regfile_init;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic [AW-1:0] rs1_addr_i;
    logic [AW-1:0] rs2_addr_i;
    logic [DW-1:0] rs1_data_o;
    logic [DW-1:0] rs2_data_o;
    logic [AW-1:0] rd_addr_i;
    logic [DW-1:0] rd_data_i;
    logic          reg_wen_i;
    logic          init_busy_o;

    int n_checks = 0;
    int n_fails  = 0;

    regfile_init #(.DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .rs1_addr_i  (rs1_addr_i),
        .rs2_addr_i  (rs2_addr_i),
        .rs1_data_o  (rs1_data_o),
        .rs2_data_o  (rs2_data_o),
        .rd_addr_i   (rd_addr_i),
        .rd_data_i   (rd_data_i),
        .reg_wen_i   (reg_wen_i),
        .init_busy_o (init_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] model_regs [32];
    int            clear_left  = 0;
    bit            model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            clear_left  = 31;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (clear_left > 0) begin
                clear_left = clear_left - 1;
                if (clear_left == 0) begin
                    for (int i = 0; i < 32; i++) model_regs[i] = '0;
                end
            end else if (reg_wen_i && rd_addr_i != 0) begin
                model_regs[rd_addr_i] = rd_data_i;
            end
        end
    end

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] addr);
        if (clear_left > 0 || addr == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (reg_wen_i && rd_addr_i != 0 && rd_addr_i == addr) return rd_data_i;
`endif
        return model_regs[addr];
    endfunction

    always @(negedge clk) begin
        if (model_valid) begin
            check("model_busy", {31'b0, init_busy_o}, {31'b0, clear_left > 0});
            check("model_rs1", rs1_data_o, model_read(rs1_addr_i));
            check("model_rs2", rs2_data_o, model_read(rs2_addr_i));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start at the first cycle with rst low. Count the cycles with busy high
    // until busy falls, giving up after a bounded number of cycles.
    task automatic busy_len(output int n);
        n = 0;
        @(negedge clk);
        while (init_busy_o === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        reg_wen_i = 1'b1;
        rd_addr_i = a;
        rd_data_i = d;
        step();
        reg_wen_i = 1'b0;
    endtask

    int n;

    initial begin
        rst = 1'b1; reg_wen_i = 1'b0;
        rs1_addr_i = '0; rs2_addr_i = '0; rd_addr_i = '0; rd_data_i = '0;

        // Reset sequence: rst held for 2 cycles.
        step(); step();
        rst = 1'b0;
        busy_len(n);
        check("busy_len_initial", n, 31);
        step();
        for (int a = 1; a < 32; a++) begin
            rs1_addr_i = AW'(a);
            rs2_addr_i = AW'(31 - a);
            @(negedge clk);
            check("sweep_zero", rs1_data_o, 32'h0);
            step();
        end

        // Basic write/read.
        write(5'd5, 32'hDEADBEEF);
        rs1_addr_i = 5'd5; rs2_addr_i = 5'd5;
        @(negedge clk);
        check("x5_rs1", rs1_data_o, 32'hDEADBEEF);
        check("x5_rs2", rs2_data_o, 32'hDEADBEEF);
        step();

        // Protection of x0.
        write(5'd0, 32'h12345678);
        rs1_addr_i = 5'd0; rs2_addr_i = 5'd0;
        @(negedge clk);
        check("x0_rs1", rs1_data_o, 32'h0);
        check("x0_rs2", rs2_data_o, 32'h0);
        step();

        // Same-cycle write/read hazard.
        write(5'd7, 32'h00000001);
        reg_wen_i = 1'b1; rd_addr_i = 5'd7; rd_data_i = 32'hA5A5A5A5;
        rs1_addr_i = 5'd7; rs2_addr_i = 5'd5;
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        check("hazard_same_cycle", rs1_data_o, 32'hA5A5A5A5);
`else
        check("hazard_same_cycle", rs1_data_o, 32'h00000001);
`endif
        check("hazard_other_port", rs2_data_o, 32'hDEADBEEF);
        step();
        reg_wen_i = 1'b0;
        @(negedge clk);
        check("hazard_next_cycle", rs1_data_o, 32'hA5A5A5A5);
        step();

        // Directed traffic in RUN, checked by the model every cycle.
        for (int i = 0; i < 40; i++) begin
            reg_wen_i  = (i % 3) != 2;
            rd_addr_i  = AW'((i * 7) % 32);
            rd_data_i  = 32'h01010101 * i ^ 32'h5A000000;
            rs1_addr_i = AW'((i * 7) % 32);
            rs2_addr_i = AW'((i * 7 + 25) % 32);
            step();
        end
        reg_wen_i = 1'b0;

        // Reset from RUN; a write issued during the clear is dropped.
        write(5'd5, 32'h0000CAFE);
        rst = 1'b1;
        step();
        rst = 1'b0;
        fork
            busy_len(n);
            begin
                repeat (5) step();
                write(5'd3, 32'hFFFFFFFF);
            end
        join
        check("busy_len_from_run", n, 31);
        step();
        rs1_addr_i = 5'd3; rs2_addr_i = 5'd5;
        @(negedge clk);
        check("x3_write_in_clear", rs1_data_o, 32'h0);
        check("x5_after_reset", rs2_data_o, 32'h0);
        step();

        // Reset asserted again 10 cycles into the clear.
        write(5'd9, 32'h13579BDF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        busy_len(n);
        check("busy_len_mid_clear", n, 31);
        step();
        rs1_addr_i = 5'd9; rs2_addr_i = 5'd31;
        @(negedge clk);
        check("x9_after_reclear", rs1_data_o, 32'h0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
